// File: rtl/mdu_pkg.sv
// Shared types and opcode decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_e;

    function automatic logic is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module mdu_div_step #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic         dbit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         qbit_o
);

    logic [N:0] trial;
    logic [N:0] diff;

    // rem_i < divisor keeps a successful difference within N bits
    always_comb begin
        trial  = {rem_i, dbit_i};
        diff   = trial - {1'b0, divisor_i};
        qbit_o = ~diff[N];
        rem_o  = qbit_o ? diff[N-1:0] : trial[N-1:0];
    end

endmodule

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: one bit per cycle on magnitudes, sign fix at writeback.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int unsigned CW = $clog2(N);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mdu_op_e          op_q, op_d;
    logic [N-1:0]     opd_q, opd_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;

    logic             src1_neg, src2_neg;
    logic [N-1:0]     src1_mag, src2_mag;
    logic [N:0]       mul_sum;
    logic [N-1:0]     div_rem;
    logic             div_qbit;
    logic [2*N-1:0]   step;
    logic [2*N-1:0]   prod_fix;
    logic [N-1:0]     quo_fix, rem_fix;

    mdu_div_step #(.N(N)) u_div_step (
        .rem_i     (acc_q[2*N-1:N]),
        .dbit_i    (acc_q[N-1]),
        .divisor_i (opd_q),
        .rem_o     (div_rem),
        .qbit_o    (div_qbit)
    );

    // Operand magnitudes; -2^(N-1) maps onto itself as an unsigned value
    always_comb begin
        src1_neg = is_signed(mdu_op_e'(op)) & src1[N-1];
        src2_neg = is_signed(mdu_op_e'(op)) & src2[N-1];
        src1_mag = src1_neg ? (~src1 + N'(1)) : src1;
        src2_mag = src2_neg ? (~src2 + N'(1)) : src2;
    end

    // Multiply accumulates into the upper half and shifts the multiplier out of the lower half;
    // divide keeps the remainder above and shifts quotient bits in below the dividend.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        step     = is_div(op_q) ? {div_rem, acc_q[N-2:0], div_qbit}
                                : {mul_sum, acc_q[N-1:1]};
        prod_fix = (neg_a_q ^ neg_b_q) ? (~step + (2*N)'(1)) : step;
        quo_fix  = zero_q ? '1
                 : ((neg_a_q ^ neg_b_q) ? (~step[N-1:0] + N'(1)) : step[N-1:0]);
        rem_fix  = neg_a_q ? (~step[2*N-1:N] + N'(1)) : step[2*N-1:N];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    op_d    = mdu_op_e'(op);
                    neg_a_d = src1_neg;
                    neg_b_d = src2_neg;
                    zero_d  = (src2 == '0);
                    opd_d   = is_div(mdu_op_e'(op)) ? src2_mag : src1_mag;
                    acc_d   = is_div(mdu_op_e'(op)) ? {{N{1'b0}}, src1_mag}
                                                    : {{N{1'b0}}, src2_mag};
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                        dz_d = zero_q;
                    end else begin
                        hi_d = prod_fix[2*N-1:N];
                        lo_d = prod_fix[N-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            opd_q   <= '0;
            acc_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == S_CALC);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed table-driven bench for mdu plus hand-written multi-cycle corner sequences.
module tb_mdu;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  src1, src2;
    logic          hi_we, lo_we;
    logic [N-1:0]  wdata;
    logic          busy, done, div_zero;
    logic [N-1:0]  hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu #(.N(N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  exp_hi;
        logic [31:0]  exp_lo;
        logic         exp_dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then scramble inputs to prove they were captured
    task automatic pulse_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clk);
        start = 1'b0; src1 = $urandom; src2 = $urandom; op = 2'($urandom);
    endtask

    // Counts busy cycles starting at the first negedge after the accepting edge
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            lat++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[11];
    int   lat;

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b01, 32'd3,        32'd4,        32'd0,        32'd12,       1'b1};
        vecs[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{2'b10, 32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1};

        reset_n = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_dz",   64'(div_zero), 64'(0));
        check("reset_hi",   64'(hi), 64'(0));
        check("reset_lo",   64'(lo), 64'(0));

        for (int i = 0; i < 11; i++) begin
            pulse_start(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(N));
            check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'(0));
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].exp_dz));
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), 64'(done), 64'(0));
        end

        // Back-to-back: start accepted in the done cycle
        pulse_start(2'b00, 32'hFFFFFFFD, 32'd5);
        wait_done(lat);
        check("b2b_first_lo", 64'(lo), 64'(32'hFFFFFFF1));
        pulse_start(2'b01, 32'd7, 32'd6);
        check("b2b_accepted_busy", 64'(busy), 64'(1));
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'(N));
        check("b2b_hi", 64'(hi), 64'(0));
        check("b2b_lo", 64'(lo), 64'(42));
        @(negedge clk);

        // MTHI while idle leaves LO alone
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'(32'h1234));
        check("mthi_lo_kept", 64'(lo), 64'(42));

        // MTHI+MTLO together
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mtboth_hi", 64'(hi), 64'(32'hA5A5));
        check("mtboth_lo", 64'(lo), 64'(32'hA5A5));

        // MTLO and a second start during CALC are both ignored
        pulse_start(2'b11, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        lo_we = 1'b1; wdata = 32'hDEADBEEF;
        start = 1'b1; op = 2'b01; src1 = 32'd9; src2 = 32'd9;
        @(negedge clk);
        lo_we = 1'b0; start = 1'b0;
        check("calc_lo_held", 64'(lo), 64'(32'hA5A5));
        check("calc_hi_held", 64'(hi), 64'(32'hA5A5));
        wait_done(lat);
        check("ignored_start_latency", 64'(lat), 64'(N - 5));
        check("ignored_start_hi", 64'(hi), 64'(2));
        check("ignored_start_lo", 64'(lo), 64'(14));
        @(negedge clk);

        // Reset in the middle of a DIV abandons it
        pulse_start(2'b10, 32'hFFFFFFF9, 32'd2);
        repeat (9) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        lat = 0;
        for (int c = 0; c < int'(N) + 5; c++) begin
            if (done) lat++;
            @(negedge clk);
        end
        check("midrst_no_done", 64'(lat), 64'(0));
        check("midrst_lo_after", 64'(lo), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
